// File: rtl/mod_mult_serial.sv
// rtl/mod_mult_serial.sv - digit-serial modular multiplier, z = (a*b + mac*c) mod MOD
// Horner over b digits MSB first, with a per-step shift-subtract reduction.
module mod_mult_serial #(
    parameter int MOD = 461,
    parameter int N   = 9,
    parameter int D   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic         mac,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z
);
    localparam int K  = N / D;
    localparam int TW = N + D + 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N-1:0]  MOD_N = N'(MOD);
    localparam logic [TW-1:0] MOD_T = TW'(MOD);

    logic [1:0]    state;
    logic [N-1:0]  a_r, b_r, c_r, acc;
    logic          mac_r;
    logic [CW-1:0] cnt;

    logic [D-1:0]  digit;
    logic [TW-1:0] t, t_red;
    logic [N-1:0]  r, z_next;
    logic [N:0]    u;
    logic          accept, last;

    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(K - 1));

    // b_r is shifted left each step, so the current digit is always its top D bits
    assign digit = b_r[N-1 -: D];

    // t < MOD*2^(D+1): subtracting MOD<<k for k = D..0 leaves t < MOD
    always_comb begin
        t     = (TW'(acc) << D) + TW'(a_r) * TW'(digit);
        t_red = t;
        for (int k = D; k >= 0; k--) begin
            if (t_red >= (MOD_T << k)) begin
                t_red = t_red - (MOD_T << k);
            end
        end
        r      = N'(t_red);
        u      = {1'b0, r} + (mac_r ? {1'b0, c_r} : {(N + 1){1'b0}});
        z_next = (u >= {1'b0, MOD_N}) ? N'(u - {1'b0, MOD_N}) : N'(u);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            mac_r <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            z     <= '0;
        end else begin
            case (state)
                S_IDLE: ;
                S_RUN: begin
                    acc <= r;
                    cnt <= cnt + 1'b1;
                    b_r <= b_r << D;
                    if (last) begin
                        z     <= z_next;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // An accept in DONE overrides the return to IDLE (back-to-back operation)
            if (accept) begin
                a_r   <= (a >= MOD_N) ? a - MOD_N : a;
                c_r   <= (c >= MOD_N) ? c - MOD_N : c;
                b_r   <= b;
                mac_r <= mac;
                acc   <= '0;
                cnt   <= '0;
                state <= S_RUN;
            end
        end
    end
endmodule

// File: doc/mod_mult_serial.md
Name: mod_mult_serial

Overview:
- Parametrised, digit-serial modular multiplier: computes z = (a*b + (mac ? c : 0)) mod MOD over N-bit residues.
- Consumes b in D-bit digits, MSB first, using Horner accumulation with per-step reduction.
- Next generation of the fixed 3x3 combinational product slices in the mod-461 datapath: modulus, width and digit size are parameters.
- Adds valid/ready handshakes, operand pre-reduction and a multiply-accumulate mode.

Parameters:
- MOD, 461, modulus. Must satisfy 2^(N-1) < MOD < 2^N.
- N, 9, operand/result width in bits.
- D, 3, digit width in bits. N must be an integer multiple of D.
- K (localparam), N/D, digit steps per operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a  in  N  multiplicand. Any N-bit value accepted.
- b  in  N  multiplier. Any N-bit value accepted.
- c  in  N  addend. Any N-bit value; used only when mac=1.
- mac  in  1  1: add c; 0: plain product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  N  result, always < MOD.

Behaviour:
- Reset: asynchronous, active-high, clears all state.
  - FSM to IDLE; acc, cnt and z to 0.
  - out_valid=0, in_ready=1 one delta after rst asserts.
  - Reset mid-RUN or mid-DONE aborts the operation; the pending result is discarded and never presented.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid=1 -> latch a_r, b, c_r, mac; acc=0; cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle processes digit d = b[N-1-cnt*D -: D].
    - t = acc*2^D + a_r*d.
    - Reduce: for k=D downto 0, if t >= MOD<<k then t -= MOD<<k. Result r < MOD.
    - acc <= r; cnt++.
    - On cnt==K-1: go to DONE. z <= final value (see below). out_valid <= 1.
  - DONE: out_valid=1; z is stable until handshake.
    - out_ready=1 and in_valid=0 -> IDLE, out_valid <= 0.
    - out_ready=1 and in_valid=1 -> accept new operands in the same cycle; go directly to RUN (back-to-back).
    - out_ready=0: hold z and out_valid, whatever in_valid does.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only; no path from in_valid.
- Pre-reduction at accept:
  - a_r = (a >= MOD) ? a-MOD : a.
  - c_r = (c >= MOD) ? c-MOD : c.
  - Valid because 2^N < 2*MOD.
  - b needs no reduction; Horner yields (a_r*b) mod MOD for any b.
- Final step (last digit):
  - u = r + (mac ? c_r : 0).
  - z <= (u >= MOD) ? u-MOD : u.
  - Folded into the same cycle; no extra latency.
- Internal widths:
  - t requires N+D+1 bits (t < MOD*2^(D+1)).
  - u requires N+1 bits.
  - No truncation before reduction.
- Latency: accept in cycle 0 -> out_valid high in cycle K+1. Defaults: 4 cycles.
- Throughput: one result per K+1 cycles with out_ready held high.
- Operand registers are private copies. a, b, c and mac may change freely after the accept cycle.
- out_valid never drops without an out_ready handshake, except on reset.
- D=N is legal: K=1, single-step reduce.

Test Plan:
- Reset, then a=123, b=45, mac=0 -> z=3 (5535 mod 461), out_valid high exactly 4 cycles after accept; in_ready low during RUN.
- a=460, b=460, mac=0 -> z=1; then a=460, b=460, c=460, mac=1 -> z=0 (461 wraps).
- Pre-reduction: a=511, b=2, mac=0 -> z=100. a=0, b=511 -> z=0. a=1, b=511 -> z=50. c=500, mac=1, a=0 -> z=39.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing a/b -> z stable, in_ready=0, no accept. Raise out_ready with in_valid=1 -> same-cycle accept; next result 4 cycles later.
- Reset asserted in cycle 2 of RUN, released next cycle -> out_valid=0, z=0, in_ready=1; a new op a=2, b=3 gives z=6.
- Random sweep with MOD=461 (D=3) and a second instance MOD=13, N=4, D=2 -> every z matches (a*b + mac*c) mod MOD against a reference model, with random in_valid/out_ready throttling.
